operand_feeder: RTL

- Upstream stage for the 8-bit register/adder accumulator. It buffers incoming operands in a small first-word-fall-through FIFO and presents one operand per accepted cycle to the accumulator's data input.
- It drives zero whenever it has nothing valid. The downstream adder sums its input on every clock, so an idle input of zero keeps the running sum stable.
- Back-pressure to the producer uses a valid/ready handshake.

---
 rtl/operand_feeder.sv | 64 ++++++
 1 files changed

// File: rtl/operand_feeder.sv
// Operand feeder: FWFT FIFO in front of the register/adder accumulator.
// Presents zero on out_data whenever empty so the downstream sum holds.
module operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CNTW-1:0]  cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;
  assign out_data  = out_valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset; a write during reset/flush is never read.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush)
      mem[wp] <= in_data;
  end

endmodule
